// File: rtl/seq_mon_pkg.sv
// seq_mon_pkg: shared state encoding, successor map and wrap constants for seq_monitor
package seq_mon_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  localparam logic [2:0] WRAP_FROM = 3'd6;
  localparam logic [2:0] WRAP_TO = 3'd0;
  // Counter code order is 0,1,2,3,4,5,7,6 then back to 0; no code maps to itself.
  function automatic logic [2:0] next_code(input logic [2:0] c);
    return c == 3'd5 ? 3'd7 : c == 3'd7 ? 3'd6 : c == 3'd6 ? 3'd0 : c + 3'd1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones
//   CLK, RESET (async, active-high), INC (count one event this edge), CNT (registered count)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  output logic [W-1:0] CNT
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (INC && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign CNT = cnt_q;
endmodule

// File: rtl/seq_monitor.sv
// seq_monitor: checks a 3-bit counter against the 0,1,2,3,4,5,7,6 code sequence
//   CLK, RESET (async, active-high), EN (sample enable), Q_IN (observed code)
//   LOCK (in LOCKED), ERR / WRAP (one-cycle pulses), EXP (expected next code),
//   CYCLE_CNT / ERR_CNT (saturating event counts)
module seq_monitor
  import seq_mon_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EN,
  input  logic [2:0]    Q_IN,
  output logic          LOCK,
  output logic          ERR,
  output logic          WRAP,
  output logic [2:0]    EXP,
  output logic [CW-1:0] CYCLE_CNT,
  output logic [CW-1:0] ERR_CNT
);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  state_t     state_q, state_d;
  logic [2:0] prev_q, prev_d, exp_q, exp_d;
  logic [3:0] good_q, good_d;
  logic       lock_q, lock_d, err_q, err_d, wrap_q, wrap_d, hit;
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    hit     = Q_IN == next_code(prev_q);
    if (EN) begin
      prev_d = Q_IN;
      if (state_q == IDLE) begin
        state_d = ACQUIRE;
        good_d  = 4'd0;
      end else if (state_q == ACQUIRE) begin
        if (hit && good_q + 4'd1 == LC) begin
          state_d = LOCKED;
          good_d  = 4'd0;
        end else good_d = hit ? good_q + 4'd1 : 4'd0;
      end else begin
        // hit is required so a 6->0 can never be both a wrap and an error
        wrap_d = hit && prev_q == WRAP_FROM && Q_IN == WRAP_TO;
        err_d  = !hit;
        if (!hit) begin
          state_d = ACQUIRE;
          good_d  = 4'd0;
        end
      end
    end
    // EXP and LOCK are registered from the post-edge state so they line up with it
    exp_d  = state_d == IDLE ? 3'd0 : next_code(prev_d);
    lock_d = state_d == LOCKED;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      prev_q  <= 3'd0;
      good_q  <= 4'd0;
      exp_q   <= 3'd0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      good_q  <= good_d;
      exp_q   <= exp_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  sat_counter #(.W(CW)) u_cyc (.CLK(CLK), .RESET(RESET), .INC(wrap_d), .CNT(CYCLE_CNT));
  sat_counter #(.W(CW)) u_err (.CLK(CLK), .RESET(RESET), .INC(err_d), .CNT(ERR_CNT));
  assign LOCK = lock_q;
  assign ERR  = err_q;
  assign WRAP = wrap_q;
  assign EXP  = exp_q;
endmodule

// File: tb/tb_seq_monitor.sv
// tb_seq_monitor: directed self-checking bench for seq_monitor (CW=8 and CW=2 instances)
module tb_seq_monitor;
  logic       CLK = 1'b0, RESET = 1'b1, EN = 1'b0;
  logic [2:0] Q_IN = 3'd0;
  logic       lock_a, err_a, wrap_a, lock_b, err_b, wrap_b;
  logic [2:0] exp_a, exp_b;
  logic [7:0] cyc_a, ecnt_a;
  logic [1:0] cyc_b, ecnt_b;
  int         n_cmp = 0, n_bad = 0;
  logic [2:0] p = 3'd0;
  logic [2:0] succ [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd6};
  logic [2:0] idle_q [5] = '{3'd3, 3'd5, 3'd1, 3'd7, 3'd2};

  always #5 CLK = ~CLK;

  seq_monitor #(.LOCK_COUNT(4), .CW(8)) u_dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .Q_IN(Q_IN), .LOCK(lock_a), .ERR(err_a),
    .WRAP(wrap_a), .EXP(exp_a), .CYCLE_CNT(cyc_a), .ERR_CNT(ecnt_a));
  seq_monitor #(.LOCK_COUNT(4), .CW(2)) u_small (
    .CLK(CLK), .RESET(RESET), .EN(EN), .Q_IN(Q_IN), .LOCK(lock_b), .ERR(err_b),
    .WRAP(wrap_b), .EXP(exp_b), .CYCLE_CNT(cyc_b), .ERR_CNT(ecnt_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick(input logic [2:0] q, input logic en);
    Q_IN = q;
    EN = en;
    @(posedge CLK);
    #1;
    if (en) p = q;
  endtask

  task automatic run(input int n);
    logic [2:0] q, pp;
    for (int i = 0; i < n; i++) begin
      pp = p;
      q = succ[p];
      tick(q, 1'b1);
      chk("run_err", err_a, 0);
      chk("run_wrap", wrap_a, (pp == 3'd6 && q == 3'd0) ? 1 : 0);
      chk("run_wrap_small", wrap_b, (pp == 3'd6 && q == 3'd0) ? 1 : 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lock"}, lock_a, 0);
    chk({tag, "_err"}, err_a, 0);
    chk({tag, "_wrap"}, wrap_a, 0);
    chk({tag, "_exp"}, exp_a, 0);
    chk({tag, "_cyc"}, cyc_a, 0);
    chk({tag, "_ecnt"}, ecnt_a, 0);
    chk({tag, "_cyc_small"}, cyc_b, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk_zero("reset");
    RESET = 1'b0;
    tick(3'd0, 1'b1);
    chk("acq_lock", lock_a, 0);
    chk("acq_exp", exp_a, 1);
    tick(3'd1, 1'b1);
    tick(3'd2, 1'b1);
    tick(3'd3, 1'b1);
    chk("pre_lock", lock_a, 0);
    tick(3'd4, 1'b1);
    chk("lock_5th", lock_a, 1);
    chk("lock_exp", exp_a, 5);
    run(16);
    chk("cyc_two", cyc_a, 2);
    chk("cyc_two_small", cyc_b, 2);
    chk("ecnt_clean", ecnt_a, 0);
    tick(3'd5, 1'b1);
    chk("ok_5", err_a, 0);
    tick(3'd6, 1'b1);
    chk("skip_err", err_a, 1);
    chk("skip_ecnt", ecnt_a, 1);
    chk("skip_lock", lock_a, 0);
    chk("skip_exp", exp_a, 0);
    tick(3'd0, 1'b1);
    chk("skip_err_end", err_a, 0);
    chk("skip_wrap_none", wrap_a, 0);
    tick(3'd1, 1'b1);
    tick(3'd2, 1'b1);
    chk("relock_pre", lock_a, 0);
    tick(3'd3, 1'b1);
    chk("relock", lock_a, 1);
    chk("relock_exp", exp_a, 4);
    tick(3'd3, 1'b1);
    chk("hold_err", err_a, 1);
    chk("hold_ecnt", ecnt_a, 2);
    tick(3'd3, 1'b1);
    chk("hold2_err", err_a, 0);
    chk("hold2_ecnt", ecnt_a, 2);
    chk("hold2_lock", lock_a, 0);
    chk("hold2_exp", exp_a, 4);
    tick(3'd4, 1'b1);
    tick(3'd5, 1'b1);
    tick(3'd7, 1'b1);
    chk("hold_relock_pre", lock_a, 0);
    tick(3'd6, 1'b1);
    chk("hold_relock", lock_a, 1);
    for (int k = 0; k < 5; k++) begin
      tick(idle_q[k], 1'b0);
      chk("en0_lock", lock_a, 1);
      chk("en0_err", err_a, 0);
      chk("en0_wrap", wrap_a, 0);
      chk("en0_exp", exp_a, 0);
      chk("en0_cyc", cyc_a, 2);
      chk("en0_ecnt", ecnt_a, 2);
    end
    tick(3'd0, 1'b1);
    chk("resume_wrap", wrap_a, 1);
    chk("resume_cyc", cyc_a, 3);
    chk("resume_cyc_small", cyc_b, 3);
    chk("resume_exp", exp_a, 1);
    run(24);
    chk("cyc_six", cyc_a, 6);
    chk("sat_small", cyc_b, 3);
    chk("pre_rst_wrap", wrap_a, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk_zero("async_rst");
    #3;
    RESET = 1'b0;
    tick(3'd0, 1'b1);
    chk("rst_acq_lock", lock_a, 0);
    chk("rst_acq_exp", exp_a, 1);
    tick(3'd1, 1'b1);
    tick(3'd2, 1'b1);
    tick(3'd3, 1'b1);
    chk("rst_pre_lock", lock_a, 0);
    tick(3'd4, 1'b1);
    chk("rst_lock", lock_a, 1);
    chk("rst_cyc", cyc_a, 0);
    chk("rst_ecnt", ecnt_a, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
